gnrl_skid_buf: RTL

GNRL_SKID_BUF -- requirements
Module: gnrl_skid_buf

---
 rtl/gnrl_skid_buf_pkg.sv | 11 +
 rtl/gnrl_dffl.sv | 19 +
 rtl/gnrl_skid_buf.sv | 104 ++++++++++
 3 files changed

// File: rtl/gnrl_skid_buf_pkg.sv
// Shared general definitions for the skid buffer: controller state encodings.
package gnrl_skid_buf_pkg;

    // Encodings double as the held-entry count (0, 1, 2).
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/gnrl_dffl.sv
// General load-enable flop without reset; holds its value when lden is low.
module gnrl_dffl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // NOTE: datapath registers carry no reset; validity is tracked by the
    // controller state, so resetting them only costs routing and power.
    always_ff @(posedge clk) begin
        if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/gnrl_skid_buf.sv
// Two-entry skid buffer: registered i_ready, head served from MAIN, overflow in SKID.
module gnrl_skid_buf
    import gnrl_skid_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
);

    skid_state_e           state_q;
    skid_state_e           state_nxt;
    logic                  ready_q;
    logic                  in_fire;
    logic                  out_fire;
    logic                  main_en;
    logic                  skid_en;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;

    assign in_fire  = i_valid && ready_q;
    assign out_fire = o_valid && o_ready;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt = state_q;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = i_data;
        case (state_q)
            SKID_EMPTY: begin
                if (in_fire) begin
                    state_nxt = SKID_ONE;
                    main_en   = 1'b1;
                end
            end
            SKID_ONE: begin
                if (in_fire && !out_fire) begin
                    state_nxt = SKID_FULL;
                    skid_en   = 1'b1;
                end else if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (out_fire) begin
                    state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_fire) begin
                    state_nxt = SKID_ONE;
                    main_en   = 1'b1;
                    main_d    = skid_q;
                end
            end
            default: state_nxt = SKID_EMPTY;
        endcase
        if (flush) begin
            state_nxt = SKID_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            // Registered copy of "not FULL next cycle"; it first rises at the
            // first posedge after reset release.
            ready_q <= (state_nxt != SKID_FULL);
        end
    end

    gnrl_dffl #(.DW(DATA_WIDTH)) u_main (
        .clk  (clk),
        .lden (main_en),
        .dnxt (main_d),
        .qout (main_q)
    );

    gnrl_dffl #(.DW(DATA_WIDTH)) u_skid (
        .clk  (clk),
        .lden (skid_en),
        .dnxt (i_data),
        .qout (skid_q)
    );

    assign i_ready = ready_q;
    assign o_valid = (state_q != SKID_EMPTY);
    assign o_data  = main_q;
    assign o_count = 2'(state_q);

endmodule
